// File: rtl/conv2_pkg.sv
// Shared types and constants for the conv2 kernel-weight fetch path.
package conv2_pkg;
    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 16;
    localparam int KLEN_DEF   = 25;
    localparam int NKERN_DEF  = 8;
    localparam int FIFO_DEPTH = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] w_a;
        logic [DATA_W-1:0] w_b;
        logic              w_b_vld;
        logic              last;
    } beat_t;
endpackage

// File: rtl/conv2_wfifo.sv
// 3-entry synchronous FIFO of weight beats with occupancy output.
// Pushing while full is never requested by the sequencer (issue throttling).
module conv2_wfifo
    import conv2_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  beat_t      din,
    input  logic       pop,
    output beat_t      dout,
    output logic [1:0] count
);
    beat_t      mem_q [FIFO_DEPTH];
    beat_t      mem_d [FIFO_DEPTH];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // next-state: push and pop in the same cycle are both honoured
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // storage and pointer registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/conv2_k_fetch.sv
// conv2 kernel-weight fetch sequencer: walks one kernel, two ROM addresses
// per cycle, and streams weight pairs through a 3-entry skid FIFO.
// Optional macro CONV2_FETCH_BOUNDS_EN: reject kidx >= NKERN and pulse err.
module conv2_k_fetch
    import conv2_pkg::*;
#(
    parameter int KLEN  = KLEN_DEF,
    parameter int NKERN = NKERN_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        kidx,
    output logic              busy,
    output logic              done,
`ifdef CONV2_FETCH_BOUNDS_EN
    output logic              err,
`endif
    output logic [ADDR_W-1:0] address_a,
    output logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] q_a,
    input  logic [DATA_W-1:0] q_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] w_a,
    output logic [DATA_W-1:0] w_b,
    output logic              w_b_vld,
    output logic              out_last
);
    localparam int         NBEAT    = (KLEN + 1) / 2;
    localparam logic [7:0] KLEN_B   = 8'(KLEN % 256);  // product mod 256 only needs KLEN mod 256
    localparam bit         KLEN_ODD = (KLEN % 2) == 1;
`ifdef CONV2_FETCH_BOUNDS_EN
    localparam bit         BOUNDS_EN = 1'b1;
`else
    localparam bit         BOUNDS_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [7:0]  base_q, base_d;
    logic [7:0]  p_q, p_d;
    logic [7:0]  addr_a_q, addr_a_d;
    logic [7:0]  addr_b_q, addr_b_d;
    logic        inflight_q, inflight_d;
    logic        tag_vld_q, tag_vld_d;
    logic        tag_last_q, tag_last_d;
`ifdef CONV2_FETCH_BOUNDS_EN
    logic        err_q, err_d;
`endif

    logic        issue, issue_ok, beat_last, kidx_ok, pop;
    logic [1:0]  fifo_count;
    logic [7:0]  beat_off;
    beat_t       push_beat, head;

    assign kidx_ok   = !BOUNDS_EN || ({24'd0, kidx} < 32'(NKERN));
    assign beat_last = (p_q == 8'(NBEAT - 1));
    assign beat_off  = 8'({p_q, 1'b0});
    // fifo slots already taken plus the beat still in the ROM pipe
    assign issue_ok  = ({1'b0, fifo_count} + {2'b0, inflight_q}) < 3'(FIFO_DEPTH);

    // sequencer next-state: IDLE -> ISSUE (one beat per allowed cycle) -> DRAIN
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        p_d        = p_q;
        inflight_d = 1'b0;
        tag_vld_d  = tag_vld_q;
        tag_last_d = tag_last_q;
`ifdef CONV2_FETCH_BOUNDS_EN
        err_d      = 1'b0;
`endif
        issue      = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (kidx_ok) begin
                    state_d = ISSUE;
                    base_d  = kidx * KLEN_B;
                    p_d     = '0;
                end
`ifdef CONV2_FETCH_BOUNDS_EN
                else err_d = 1'b1;
`endif
            end
            ISSUE: if (issue_ok) begin
                issue      = 1'b1;
                inflight_d = 1'b1;
                p_d        = p_q + 8'd1;
                tag_last_d = beat_last;
                tag_vld_d  = !(beat_last && KLEN_ODD);
                if (beat_last) state_d = DRAIN;
            end
            DRAIN: if (pop && head.last) begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ROM addresses: driven on issue, otherwise hold the last issued pair
    always_comb begin
        address_a = issue ? base_q + beat_off        : addr_a_q;
        address_b = issue ? base_q + beat_off + 8'd1 : addr_b_q;
        addr_a_d  = address_a;
        addr_b_d  = address_b;
    end

    // sequencer, address and ROM-tag registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            p_q        <= '0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            inflight_q <= 1'b0;
            tag_vld_q  <= 1'b0;
            tag_last_q <= 1'b0;
`ifdef CONV2_FETCH_BOUNDS_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            p_q        <= p_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            inflight_q <= inflight_d;
            tag_vld_q  <= tag_vld_d;
            tag_last_q <= tag_last_d;
`ifdef CONV2_FETCH_BOUNDS_EN
            err_q      <= err_d;
`endif
        end
    end

    // ROM data lands one cycle after issue; odd tail gets w_b zeroed
    always_comb begin
        push_beat.w_a     = q_a;
        push_beat.w_b     = tag_vld_q ? q_b : '0;
        push_beat.w_b_vld = tag_vld_q;
        push_beat.last    = tag_last_q;
    end

    conv2_wfifo u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (inflight_q),
        .din   (push_beat),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count)
    );

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid & out_ready;
    assign w_a       = head.w_a;
    assign w_b       = head.w_b;
    assign w_b_vld   = head.w_b_vld;
    assign out_last  = head.last;
    assign busy      = (state_q != IDLE);
`ifdef CONV2_FETCH_BOUNDS_EN
    assign err       = err_q;
`endif
endmodule
